// File: rtl/pcw_sd_pkg.sv
// Shared types and the round-robin pick for the PCW SD-lane arbiter.
package pcw_sd_pkg;

  typedef enum logic [1:0] {IDLE, REQ, XFER, DONE} sd_arb_state_t;

  localparam int SECTOR_BYTES = 512;

  typedef struct packed {
    logic [31:0] lba;
    logic        op_wr;
  } sd_req_t;

  // With both drives pending the one that was not served last wins.
  function automatic logic rr_pick(input logic [1:0] pending, input logic last);
    if (pending == 2'b11) return ~last;
    else if (pending[1])  return 1'b1;
    else                  return 1'b0;
  endfunction

endpackage

// File: rtl/pcw_sd_arbiter.sv
// Shares the single host SD lane between the two PCW floppy drives,
// one whole sector transfer at a time, with round-robin fairness and a request timeout.
//
// state | meaning
// IDLE  | no transfer; pick a pending drive and latch its request
// REQ   | sd_rd/sd_wr held, waiting for sd_ack, timer running
// XFER  | host ack high, data/ack routed to the granted drive
// DONE  | one cycle so the drive sees ack fall before any regrant
module pcw_sd_arbiter
  import pcw_sd_pkg::*;
#(
  parameter int               TMR_W   = 24,
  parameter logic [TMR_W-1:0] TIMEOUT = 24'd16_000_000
) (
  input  logic             clk_sys,
  input  logic             reset_n,
  input  logic [1:0][31:0] dev_lba,
  input  logic [1:0]       dev_rd,
  input  logic [1:0]       dev_wr,
  output logic [1:0]       dev_ack,
  output logic [1:0]       dev_err,
  input  logic [1:0][7:0]  dev_buff_din,
  output logic [1:0]       dev_buff_wr,
  output logic [31:0]      sd_lba,
  output logic             sd_rd,
  output logic             sd_wr,
  input  logic             sd_ack,
  output logic [7:0]       sd_buff_din,
  input  logic             sd_buff_wr,
  output logic             grant,
  output logic             busy
);

  sd_arb_state_t    state, state_n;
  logic [TMR_W-1:0] timer, timer_n;
  sd_req_t          req, req_n;
  logic             grant_q, grant_n;
  logic             last_grant, last_n;
  logic [1:0]       pending;
  logic             pick;

  assign pending = dev_rd | dev_wr;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      timer      <= '0;
      req        <= '0;
      grant_q    <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      state      <= state_n;
      timer      <= timer_n;
      req        <= req_n;
      grant_q    <= grant_n;
      last_grant <= last_n;
    end
  end

  always_comb begin
    state_n = state;
    timer_n = timer;
    req_n   = req;
    grant_n = grant_q;
    last_n  = last_grant;
    pick    = rr_pick(pending, last_grant);
    dev_err = 2'b00;
    unique case (state)
      IDLE: begin
        timer_n = '0;
        if (|pending) begin
          grant_n   = pick;
          req_n.lba = dev_lba[pick];
          // write wins when a drive raises both levels
          req_n.op_wr = dev_wr[pick];
          state_n   = REQ;
        end
      end
      REQ: begin
        if (sd_ack) begin
          timer_n = '0;
          state_n = XFER;
        end else if (timer == TIMEOUT - 1'b1) begin
          dev_err[grant_q] = 1'b1;
          last_n  = grant_q;
          timer_n = '0;
          state_n = IDLE;
        end else begin
          timer_n = timer + 1'b1;
        end
      end
      XFER: begin
        if (!sd_ack) state_n = DONE;
      end
      DONE: begin
        last_n  = grant_q;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    dev_ack     = 2'b00;
    dev_buff_wr = 2'b00;
    sd_buff_din = 8'h00;
    if (state == XFER) begin
      dev_ack[grant_q]     = sd_ack;
      dev_buff_wr[grant_q] = sd_buff_wr;
      sd_buff_din          = dev_buff_din[grant_q];
    end
  end

  assign sd_rd  = (state == REQ) && !req.op_wr;
  assign sd_wr  = (state == REQ) &&  req.op_wr;
  assign sd_lba = req.lba;
  assign grant  = grant_q;
  assign busy   = (state != IDLE);

endmodule

// File: tb/tb_pcw_sd_arbiter.sv
// Directed bench for pcw_sd_arbiter: a scripted host drives sd_ack/sd_buff_wr
// and each scenario task checks the arbiter's outputs against hand-derived values.
module tb_pcw_sd_arbiter;

  logic             clk_sys = 1'b0;
  logic             reset_n;
  logic [1:0][31:0] dev_lba;
  logic [1:0]       dev_rd, dev_wr;
  logic [1:0]       dev_ack, dev_err;
  logic [1:0][7:0]  dev_buff_din;
  logic [1:0]       dev_buff_wr;
  logic [31:0]      sd_lba;
  logic             sd_rd, sd_wr;
  logic             sd_ack;
  logic [7:0]       sd_buff_din;
  logic             sd_buff_wr;
  logic             grant, busy;

  int vectors = 0;
  int miscompares = 0;

  int n_ack0, n_ack1, n_bw0, n_bw1, n_din_bad, n_req_x;
  logic [1:0] fall_ack;

  pcw_sd_arbiter #(.TMR_W(24), .TIMEOUT(24'd100)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n),
    .dev_lba(dev_lba), .dev_rd(dev_rd), .dev_wr(dev_wr),
    .dev_ack(dev_ack), .dev_err(dev_err),
    .dev_buff_din(dev_buff_din), .dev_buff_wr(dev_buff_wr),
    .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr), .sd_ack(sd_ack),
    .sd_buff_din(sd_buff_din), .sd_buff_wr(sd_buff_wr),
    .grant(grant), .busy(busy)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic step();
    @(posedge clk_sys);
    #2;
  endtask

  task automatic do_reset();
    reset_n    = 1'b0;
    sd_ack     = 1'b0;
    sd_buff_wr = 1'b0;
    step();
    step();
    reset_n = 1'b1;
  endtask

  // Called in the first REQ cycle; ack rises `delay` cycles later and is held `len` cycles.
  task automatic host_xfer(input int delay, input int len, input int nstr, input logic [7:0] exp_din);
    n_ack0 = 0; n_ack1 = 0; n_bw0 = 0; n_bw1 = 0; n_din_bad = 0; n_req_x = 0;
    repeat (delay) step();
    sd_ack = 1'b1;
    for (int j = 0; j < len; j++) begin
      sd_buff_wr = (j >= 2) && (j < 2 + nstr);
      #1;
      if (dev_ack[0]) n_ack0++;
      if (dev_ack[1]) n_ack1++;
      if (dev_buff_wr[0]) n_bw0++;
      if (dev_buff_wr[1]) n_bw1++;
      if (j >= 1 && sd_buff_din !== exp_din) n_din_bad++;
      if (j >= 1 && (sd_rd || sd_wr)) n_req_x++;
      step();
    end
    sd_ack     = 1'b0;
    sd_buff_wr = 1'b0;
    #1;
    fall_ack = dev_ack;
  endtask

  task automatic test_reset();
    dev_lba = '0; dev_rd = 2'b01; dev_wr = 2'b00; dev_buff_din = '0;
    reset_n = 1'b0; sd_ack = 1'b0; sd_buff_wr = 1'b0;
    step(); step(); #1;
    vectors++;
    if ({sd_rd, sd_wr, dev_ack, dev_err, dev_buff_wr, grant, busy} !== 10'b0) begin
      miscompares++;
      $display("FAIL reset_ctrl: got %b expected 0", {sd_rd, sd_wr, dev_ack, dev_err, dev_buff_wr, grant, busy});
    end
    vectors++;
    if (sd_lba !== 32'h0 || sd_buff_din !== 8'h0) begin
      miscompares++;
      $display("FAIL reset_data: got lba %h din %h expected 0", sd_lba, sd_buff_din);
    end
    dev_rd = 2'b00;
    step();
    reset_n = 1'b1;
  endtask

  task automatic test_single_read();
    dev_lba[0] = 32'h0000_0010; dev_lba[1] = 32'h0000_0099;
    dev_buff_din[0] = 8'h11; dev_buff_din[1] = 8'h22;
    dev_rd = 2'b01;
    step(); #1;
    vectors++;
    if ({sd_rd, sd_wr, grant, busy} !== 4'b1001) begin
      miscompares++;
      $display("FAIL rd_issue: got rd/wr/grant/busy %b expected 1001", {sd_rd, sd_wr, grant, busy});
    end
    vectors++;
    if (sd_lba !== 32'h10) begin
      miscompares++; $display("FAIL rd_lba: got %h expected 00000010", sd_lba);
    end
    dev_rd = 2'b00;
    dev_lba[0] = 32'hDEAD_BEEF;
    host_xfer(5, 520, 512, 8'h11);
    // the first ack cycle is still seen in REQ, so 519 of the 520 ack cycles reach the drive
    vectors++;
    if (n_ack0 !== 519 || n_ack1 !== 0) begin
      miscompares++; $display("FAIL rd_ack_window: got %0d/%0d expected 519/0", n_ack0, n_ack1);
    end
    vectors++;
    if (n_bw0 !== 512 || n_bw1 !== 0) begin
      miscompares++; $display("FAIL rd_strobes: got %0d/%0d expected 512/0", n_bw0, n_bw1);
    end
    vectors++;
    if (n_din_bad !== 0 || n_req_x !== 0) begin
      miscompares++; $display("FAIL rd_xfer_outputs: got din_bad %0d req_in_xfer %0d expected 0/0", n_din_bad, n_req_x);
    end
    vectors++;
    if (fall_ack !== 2'b00 || sd_lba !== 32'h10) begin
      miscompares++; $display("FAIL rd_ack_fall: got ack %b lba %h expected 00 00000010", fall_ack, sd_lba);
    end
    step(); #1;
    vectors++;
    if (busy !== 1'b1 || dev_ack !== 2'b00) begin
      miscompares++; $display("FAIL rd_done: got busy %b ack %b expected 1 00", busy, dev_ack);
    end
    step(); #1;
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++; $display("FAIL rd_idle: got busy %b expected 0", busy);
    end
  endtask

  task automatic test_simultaneous();
    dev_lba[0] = 32'h100; dev_lba[1] = 32'h200;
    dev_rd = 2'b11; dev_wr = 2'b00;
    do_reset();
    step(); #1;
    vectors++;
    if ({grant, sd_rd} !== 2'b01 || sd_lba !== 32'h100) begin
      miscompares++; $display("FAIL sim_first: got grant %b rd %b lba %h expected 0 1 00000100", grant, sd_rd, sd_lba);
    end
    dev_rd = 2'b10;
    host_xfer(3, 10, 4, 8'h11);
    vectors++;
    if (n_ack0 !== 9 || n_ack1 !== 0 || n_bw0 !== 4 || n_bw1 !== 0) begin
      miscompares++; $display("FAIL sim_xfer0: got ack %0d/%0d bw %0d/%0d expected 9/0 4/0", n_ack0, n_ack1, n_bw0, n_bw1);
    end
    step(); step(); #1;
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++; $display("FAIL sim_gap: got busy %b expected 0", busy);
    end
    step(); #1;
    vectors++;
    if ({grant, sd_rd} !== 2'b11 || sd_lba !== 32'h200) begin
      miscompares++; $display("FAIL sim_second: got grant %b rd %b lba %h expected 1 1 00000200", grant, sd_rd, sd_lba);
    end
    dev_rd = 2'b00;
    host_xfer(3, 10, 4, 8'h22);
    vectors++;
    if (n_ack0 !== 0 || n_ack1 !== 9 || n_bw0 !== 0 || n_bw1 !== 4 || n_din_bad !== 0) begin
      miscompares++;
      $display("FAIL sim_xfer1: got ack %0d/%0d bw %0d/%0d din_bad %0d expected 0/9 0/4 0", n_ack0, n_ack1, n_bw0, n_bw1, n_din_bad);
    end
    step(); step();
  endtask

  task automatic test_round_robin();
    logic exp_g;
    dev_rd = 2'b11; dev_wr = 2'b00;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      exp_g = (k % 2 == 1);
      step(); #1;
      vectors++;
      if (grant !== exp_g || sd_rd !== 1'b1) begin
        miscompares++; $display("FAIL rr_grant_%0d: got grant %b rd %b expected %b 1", k, grant, sd_rd, exp_g);
      end
      host_xfer(1, 3, 0, exp_g ? 8'h22 : 8'h11);
      vectors++;
      if ((exp_g ? n_ack1 : n_ack0) !== 2 || (exp_g ? n_ack0 : n_ack1) !== 0 || n_din_bad !== 0) begin
        miscompares++; $display("FAIL rr_xfer_%0d: got ack %0d/%0d din_bad %0d", k, n_ack0, n_ack1, n_din_bad);
      end
      step(); step();
    end
    dev_rd = 2'b00;
    step();
  endtask

  task automatic test_write_precedence();
    dev_lba[1] = 32'h55; dev_buff_din[0] = 8'h3C; dev_buff_din[1] = 8'hA5;
    dev_rd = 2'b10; dev_wr = 2'b10;
    do_reset();
    step(); #1;
    vectors++;
    if ({sd_wr, sd_rd, grant} !== 3'b101 || sd_lba !== 32'h55) begin
      miscompares++; $display("FAIL wp_write_first: got wr/rd/grant %b lba %h expected 101 00000055", {sd_wr, sd_rd, grant}, sd_lba);
    end
    dev_wr = 2'b00;
    host_xfer(2, 20, 10, 8'hA5);
    vectors++;
    if (n_din_bad !== 0 || n_bw1 !== 10 || n_bw0 !== 0 || n_ack1 !== 19) begin
      miscompares++;
      $display("FAIL wp_xfer: got din_bad %0d bw %0d/%0d ack1 %0d expected 0 0/10 19", n_din_bad, n_bw0, n_bw1, n_ack1);
    end
    step();
    sd_buff_wr = 1'b1;
    #1;
    vectors++;
    if (dev_buff_wr !== 2'b00 || sd_buff_din !== 8'h00 || busy !== 1'b1) begin
      miscompares++; $display("FAIL wp_done_quiet: got bw %b din %h busy %b expected 00 00 1", dev_buff_wr, sd_buff_din, busy);
    end
    sd_buff_wr = 1'b0;
    step(); step(); #1;
    vectors++;
    if ({sd_rd, sd_wr, grant} !== 3'b101) begin
      miscompares++; $display("FAIL wp_read_after: got rd/wr/grant %b expected 101", {sd_rd, sd_wr, grant});
    end
    dev_rd = 2'b00;
    host_xfer(1, 3, 0, 8'hA5);
    step(); step();
  endtask

  task automatic test_timeout();
    int n_wr, n_err, err_at;
    logic [1:0] err_val, err_after;
    logic busy_after;
    n_wr = 0; n_err = 0; err_at = -1; err_val = 2'b00; err_after = 2'b11; busy_after = 1'b1;
    dev_rd = 2'b00; dev_wr = 2'b10;
    do_reset();
    step();
    for (int i = 0; i < 200; i++) begin
      #1;
      if (sd_wr) n_wr++;
      if (!sd_wr) begin
        busy_after = busy; err_after = dev_err;
        break;
      end
      if (dev_err != 2'b00) begin
        n_err++; err_val = dev_err; err_at = i; dev_wr = 2'b00;
      end
      step();
    end
    vectors++;
    if (n_wr !== 100) begin
      miscompares++; $display("FAIL to_wr_cycles: got %0d expected 100", n_wr);
    end
    vectors++;
    if (n_err !== 1 || err_val !== 2'b10 || err_at !== 99) begin
      miscompares++; $display("FAIL to_err_pulse: got count %0d val %b at %0d expected 1 10 99", n_err, err_val, err_at);
    end
    vectors++;
    if (busy_after !== 1'b0 || err_after !== 2'b00) begin
      miscompares++; $display("FAIL to_after: got busy %b err %b expected 0 00", busy_after, err_after);
    end
    step(); #1;
    vectors++;
    if ({busy, sd_wr, sd_rd} !== 3'b000) begin
      miscompares++; $display("FAIL to_no_regrant: got busy/wr/rd %b expected 000", {busy, sd_wr, sd_rd});
    end
  endtask

  task automatic test_reset_mid_xfer();
    dev_lba[0] = 32'h77; dev_buff_din[0] = 8'h11;
    dev_rd = 2'b01; dev_wr = 2'b00;
    do_reset();
    step();
    step();
    sd_ack = 1'b1;
    step();
    for (int k = 0; k < 200; k++) begin
      sd_buff_wr = 1'b1;
      step();
    end
    #1;
    vectors++;
    if (dev_buff_wr !== 2'b01 || dev_ack !== 2'b01) begin
      miscompares++; $display("FAIL rm_in_xfer: got bw %b ack %b expected 01 01", dev_buff_wr, dev_ack);
    end
    reset_n = 1'b0;
    #1;
    vectors++;
    if ({sd_rd, sd_wr, dev_ack, dev_err, dev_buff_wr, grant, busy} !== 10'b0 || sd_lba !== 32'h0 || sd_buff_din !== 8'h0) begin
      miscompares++;
      $display("FAIL rm_async_clear: got ctrl %b lba %h din %h expected 0",
               {sd_rd, sd_wr, dev_ack, dev_err, dev_buff_wr, grant, busy}, sd_lba, sd_buff_din);
    end
    sd_ack = 1'b0; sd_buff_wr = 1'b0; dev_rd = 2'b11;
    step();
    reset_n = 1'b1;
    step(); #1;
    vectors++;
    if ({sd_rd, grant} !== 2'b10 || sd_lba !== 32'h77) begin
      miscompares++; $display("FAIL rm_regrant: got rd %b grant %b lba %h expected 1 0 00000077", sd_rd, grant, sd_lba);
    end
    dev_rd = 2'b00;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_read();
    test_simultaneous();
    test_round_robin();
    test_write_precedence();
    test_timeout();
    test_reset_mid_xfer();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
